apb_mem_slave: RTL and testbench

- Parametrised APB memory slave and next generation of the team's 8-bit APB slave.
- Configurable data width, address width and memory depth; byte-lane write strobes; address decode errors reported on pslverr.
- Optional programmable wait states.
- Sits behind the APB bridge as a register/scratch-RAM target. One transfer at a time; back-to-back transfers supported.

---
 rtl/apb_mem_slave.sv | 143 ++++++++++++++
 tb/tb_apb_mem_slave.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: parametrised APB scratch-RAM slave with byte-lane strobes.
// Define APB_WAIT_STATES_EN to insert WAIT_CYCLES wait states per transfer.
module apb_mem_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    presetn,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic                    pslverr,
    output logic [DATA_WIDTH-1:0]   prdata
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = ADDR_WIDTH - LSB;
    localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [IW-1:0]         widx;
    logic                  align_err;
    logic                  range_err;
    logic                  setup;
    logic                  cnt_zero;
    logic                  done;
    logic                  err_q;
    logic                  wr_q;
    logic [MW-1:0]         idx_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign widx  = paddr[ADDR_WIDTH-1:LSB];
    assign setup = (state_q == IDLE) && psel && !penable;

    generate
        if (LSB > 0) begin : g_align
            assign align_err = |paddr[LSB-1:0];
        end else begin : g_noalign
            assign align_err = 1'b0;
        end
    endgenerate

    assign range_err = {1'b0, widx} >= (IW + 1)'(DEPTH);

`ifdef APB_WAIT_STATES_EN
    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge presetn) begin
        if (!presetn) begin
            cnt_q <= '0;
        end else if (setup) begin
            cnt_q <= 4'(WAIT_CYCLES);
        end else if (state_q == ACCESS && psel && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end else if (state_d == IDLE) begin
            cnt_q <= '0;
        end
    end

    assign cnt_zero = (cnt_q == 4'd0);
`else
    assign cnt_zero = 1'b1;
`endif

    // Decode is captured in SETUP; the APB master holds the address stable.
    always_ff @(posedge clk or negedge presetn) begin
        if (!presetn) begin
            err_q <= 1'b0;
            wr_q  <= 1'b0;
            idx_q <= '0;
        end else if (setup) begin
            err_q <= align_err | range_err;
            wr_q  <= pwrite;
            idx_q <= widx[MW-1:0];
        end
    end

    always_ff @(posedge clk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel || cnt_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        if (state_q == ACCESS && psel && cnt_zero) begin
            pready  = 1'b1;
            pslverr = err_q;
            if (!wr_q && !err_q) begin
                prdata = mem[idx_q];
            end
        end
    end

    assign done = pready && wr_q && !err_q;

    // Memory has no reset so contents survive presetn.
    always_ff @(posedge clk) begin
        if (done) begin
            for (int i = 0; i < NB; i++) begin
                if (pstrb[i]) begin
                    mem[idx_q][i*8 +: 8] <= pwdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: directed vector bench for apb_mem_slave.
// Covers strobes, decode errors, abort, stray penable and async reset.
module tb_apb_mem_slave;

`ifdef APB_WAIT_STATES_EN
    localparam int NW = 2;
`else
    localparam int NW = 0;
`endif

    logic        clk = 1'b0;
    logic        presetn = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    int n_vec = 0;
    int n_bad = 0;

    apb_mem_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (12),
        .DEPTH      (256),
        .WAIT_CYCLES(2)
    ) dut (
        .clk    (clk),
        .presetn(presetn),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .pstrb  (pstrb),
        .pready (pready),
        .pslverr(pslverr),
        .prdata (prdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vt[18];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the completing edge.
    task automatic xfer(input bit wr, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic err,
                        output int cyc);
        bit got;
        got = 0;
        rd = 'x;
        err = 1'bx;
        psel = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = addr;
        pwdata = wd;
        pstrb = st;
        @(negedge clk);
        check("setup_pready", {31'b0, pready}, 32'd0);
        @(posedge clk);
        #1 penable = 1'b1;
        cyc = 2;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (pready) begin
                got = 1;
                rd = prdata;
                err = pslverr;
            end
            @(posedge clk);
            #1;
            if (!got) cyc++;
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: no pready after %0d cycles", cyc);
        end
        psel = 1'b0;
        penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          cyc;

    initial begin
        vt[0]  = '{1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0, 0};
        vt[1]  = '{0, 12'h010, 32'h0,        4'h0, 32'hDEADBEEF, 0};
        vt[2]  = '{1, 12'h010, 32'h11223344, 4'h5, 32'h0, 0};
        vt[3]  = '{0, 12'h010, 32'h0,        4'hF, 32'hDE22BE44, 0};
        vt[4]  = '{0, 12'h012, 32'h0,        4'h0, 32'h0, 1};
        vt[5]  = '{0, 12'h400, 32'h0,        4'h0, 32'h0, 1};
        vt[6]  = '{1, 12'h000, 32'h12345678, 4'hF, 32'h0, 0};
        vt[7]  = '{1, 12'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1};
        vt[8]  = '{0, 12'h000, 32'h0,        4'h0, 32'h12345678, 0};
        vt[9]  = '{1, 12'h3FC, 32'hA5A5A5A5, 4'hF, 32'h0, 0};
        vt[10] = '{0, 12'h3FC, 32'h0,        4'h0, 32'hA5A5A5A5, 0};
        vt[11] = '{1, 12'h020, 32'h0BADF00D, 4'hF, 32'h0, 0};
        vt[12] = '{1, 12'h020, 32'hFFFFFFFF, 4'h0, 32'h0, 0};
        vt[13] = '{0, 12'h020, 32'h0,        4'h0, 32'h0BADF00D, 0};
        vt[14] = '{1, 12'h001, 32'h99999999, 4'hF, 32'h0, 1};
        vt[15] = '{0, 12'h000, 32'h0,        4'h0, 32'h12345678, 0};
        vt[16] = '{1, 12'h024, 32'h77665544, 4'hA, 32'h0, 0};
        vt[17] = '{0, 12'hFFC, 32'h0,        4'h0, 32'h0, 1};

        #13;
        check("reset_pready", {31'b0, pready}, 32'd0);
        check("reset_pslverr", {31'b0, pslverr}, 32'd0);
        check("reset_prdata", prdata, 32'd0);
        presetn = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back: each xfer issues SETUP right after the prior edge.
        for (int i = 0; i < 18; i++) begin
            xfer(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, rd, er, cyc);
            check($sformatf("v%0d_err", i), {31'b0, er},
                  {31'b0, vt[i].exp_err});
            check($sformatf("v%0d_cycles", i), cyc, NW + 2);
            if (!vt[i].wr)
                check($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
        end

        // Abort: drop psel in the first ACCESS cycle of a write.
        psel = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 12'h020;
        pwdata = 32'hCAFEF00D;
        pstrb = 4'hF;
        @(posedge clk);
        #1 penable = 1'b1;
`ifdef APB_WAIT_STATES_EN
        @(negedge clk);
        check("abort_wait_pready", {31'b0, pready}, 32'd0);
        @(posedge clk);
        #1;
`endif
        psel = 1'b0;
        @(negedge clk);
        check("abort_pready", {31'b0, pready}, 32'd0);
        @(posedge clk);
        #1 penable = 1'b0;
        @(posedge clk);
        #1;
        xfer(0, 12'h020, 32'h0, 4'h0, rd, er, cyc);
        check("abort_rdata", rd, 32'h0BADF00D);

        // penable without a preceding SETUP is ignored.
        psel = 1'b1;
        penable = 1'b1;
        pwrite = 1'b0;
        paddr = 12'h010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stray_pready", {31'b0, pready}, 32'd0);
        end
        psel = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset in the completing ACCESS cycle of a read.
        psel = 1'b1;
        pwrite = 1'b0;
        paddr = 12'h010;
        @(posedge clk);
        #1 penable = 1'b1;
        for (int k = 0; k < NW; k++) begin
            @(posedge clk);
            #1;
        end
        #1;
        check("prereset_pready", {31'b0, pready}, 32'd1);
        presetn = 1'b0;
        #1;
        check("async_pready", {31'b0, pready}, 32'd0);
        check("async_pslverr", {31'b0, pslverr}, 32'd0);
        check("async_prdata", prdata, 32'd0);
        psel = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        #3 presetn = 1'b1;
        @(posedge clk);
        #1;
        xfer(0, 12'h010, 32'h0, 4'h0, rd, er, cyc);
        check("postreset_rdata", rd, 32'hDE22BE44);
        check("postreset_cycles", cyc, NW + 2);
        xfer(0, 12'h024, 32'h0, 4'h0, rd, er, cyc);
        check("postreset_strb", rd & 32'hFF00FF00, 32'h77005500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
